// File: rtl/seg7_scan_if.sv
// Value-source / display-driver bundle for the 7-segment scanner.
// Latency: none (wires only).
// Backpressure: none; i_load is a fire-and-forget strobe, o_pending reports a queued value.
//
// Ports:
//   i_load       capture strobe for i_bcd / i_dp
//   i_bcd        NUM_DIGITS packed 4-bit codes, digit 0 in the low nibble
//   i_dp         decimal point per digit
//   o_segments   {dp, g, f, e, d, c, b, a}, active-high
//   o_digit_sel  one-hot digit enable, active-high
//   o_frame_done one-cycle pulse at the end of each frame
//   o_pending    a loaded value is waiting for the next frame start
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    i_load;
    logic [NUM_DIGITS*4-1:0] i_bcd;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic [7:0]              o_segments;
    logic [NUM_DIGITS-1:0]   o_digit_sel;
    logic                    o_frame_done;
    logic                    o_pending;

    // Value source side
    modport master (
        output i_load, i_bcd, i_dp,
        input  o_segments, o_digit_sel, o_frame_done, o_pending
    );

    // Scanner side
    modport slave (
        input  i_load, i_bcd, i_dp,
        output o_segments, o_digit_sel, o_frame_done, o_pending
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit common-cathode 7-segment driver with double-buffered values.
// Latency: a load shows from the next frame start (same frame if loaded in the START cycle).
// Backpressure: none; loads always accepted, latest pending load wins.
//
// Ports: i_clk, i_reset (synchronous, active-high), bus (seg7_scan_if.slave).
// Optional feature: define SEG7_SCAN_LEADING_ZERO_BLANK_EN to blank leading zeros.
// Frame = 1 START cycle + NUM_DIGITS*DIGIT_ON_CYCLES scan cycles + GAP_CYCLES blank cycles.
module seg7_scan_mux #(
    parameter int NUM_DIGITS      = 4,
    parameter int DIGIT_ON_CYCLES = 500,
    parameter int GAP_CYCLES      = 20000,
    parameter int CNT_W           = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    seg7_scan_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(DIGIT_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_START, ST_SCAN, ST_GAP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS*4-1:0] act_bcd_q, act_bcd_d, pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    done_q, done_d;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hE:    glyph = 7'h40;
            default: glyph = 7'h00;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_START;
            idx_q      <= '0;
            cnt_q      <= '0;
            act_bcd_q  <= '0;
            act_dp_q   <= '0;
            pend_bcd_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            act_bcd_q  <= act_bcd_d;
            act_dp_q   <= act_dp_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        act_bcd_d  = act_bcd_q;
        act_dp_d   = act_dp_q;
        pend_bcd_d = pend_bcd_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        done_d     = 1'b0;

        case (state_q)
            ST_START: begin
                // A load landing on the frame boundary bypasses the pending buffer.
                if (bus.i_load) begin
                    act_bcd_d  = bus.i_bcd;
                    act_dp_d   = bus.i_dp;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    act_bcd_d  = pend_bcd_q;
                    act_dp_d   = pend_dp_q;
                    pend_vld_d = 1'b0;
                end
                state_d = ST_SCAN;
                idx_d   = '0;
                cnt_d   = '0;
            end
            ST_SCAN: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        // Registered so the pulse lands on the first cycle after the last window.
                        done_d  = 1'b1;
                        state_d = (GAP_CYCLES == 0) ? ST_START : ST_GAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_START;
        endcase

        if (bus.i_load && (state_q != ST_START)) begin
            pend_bcd_d = bus.i_bcd;
            pend_dp_d  = bus.i_dp;
            pend_vld_d = 1'b1;
        end
    end

    // Per-digit leading-zero blank mask, derived from the active buffer only.
    logic [NUM_DIGITS-1:0] lz_blank;
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic       higher_blank;
        logic [3:0] code_k;
        higher_blank = 1'b1;
        code_k       = '0;
        lz_blank     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            code_k      = act_bcd_q[k*4 +: 4];
            lz_blank[k] = (k != 0) && higher_blank && (code_k == 4'h0);
            // Minus (0xE) is visible, so it stops the blanking run.
            higher_blank = higher_blank &&
                           ((code_k == 4'h0) || ((code_k >= 4'hA) && (code_k != 4'hE)));
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        logic [3:0] code;
        code            = act_bcd_q[idx_q*4 +: 4];
        bus.o_segments  = 8'h00;
        bus.o_digit_sel = '0;
        if (state_q == ST_SCAN) begin
            bus.o_digit_sel = NUM_DIGITS'(1) << idx_q;
            bus.o_segments  = {act_dp_q[idx_q], lz_blank[idx_q] ? 7'h00 : glyph(code)};
        end
    end

    assign bus.o_frame_done = done_q;
    assign bus.o_pending    = pend_vld_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed steps plus random loads/resets
// compared cycle by cycle against a frame-position reference model.
module tb_seg7_scan_mux;
    localparam int ND    = 4;
    localparam int ON    = 4;
    localparam int GAP   = 3;
    localparam int FRAME = 1 + ND*ON + GAP;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00
    };

    logic i_clk = 1'b0;
    logic i_reset;

    seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_mux #(
        .NUM_DIGITS     (ND),
        .DIGIT_ON_CYCLES(ON),
        .GAP_CYCLES     (GAP),
        .CNT_W          (16)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame plus shown/queued values.
    int          m_pos = 0;
    logic [15:0] m_disp_bcd = '0, m_pend_bcd = '0;
    logic [3:0]  m_disp_dp = '0, m_pend_dp = '0;
    bit          m_pend_v = 0;
    bit          m_valid = 0;

    function automatic bit hidden_zero(int d);
        bit res;
        res = 0;
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
        if (d > 0 && m_disp_bcd[d*4 +: 4] == 4'h0) begin
            res = 1;
            for (int j = d + 1; j < ND; j++) begin
                int c;
                c = int'(m_disp_bcd[j*4 +: 4]);
                if (!(c == 0 || (c >= 10 && c != 14))) res = 0;
            end
        end
`endif
        return res;
    endfunction

    task automatic check_outputs();
        logic [7:0]    exp_seg;
        logic [ND-1:0] exp_sel;
        logic          exp_done;
        int            d;
        exp_seg  = 8'h00;
        exp_sel  = '0;
        exp_done = (m_pos == 1 + ND*ON);
        if (m_pos >= 1 && m_pos <= ND*ON) begin
            d       = (m_pos - 1) / ON;
            exp_sel = ND'(1 << d);
            exp_seg = {m_disp_dp[d],
                       hidden_zero(d) ? 7'h00 : GLYPH[int'(m_disp_bcd[d*4 +: 4])]};
        end
        checks++;
        assert (bus.o_segments === exp_seg) else begin
            errors++;
            $error("FAIL segments pos=%0d got=%h exp=%h", m_pos, bus.o_segments, exp_seg);
        end
        checks++;
        assert (bus.o_digit_sel === exp_sel) else begin
            errors++;
            $error("FAIL digit_sel pos=%0d got=%b exp=%b", m_pos, bus.o_digit_sel, exp_sel);
        end
        checks++;
        assert (bus.o_frame_done === exp_done) else begin
            errors++;
            $error("FAIL frame_done pos=%0d got=%b exp=%b", m_pos, bus.o_frame_done, exp_done);
        end
        checks++;
        assert (bus.o_pending === m_pend_v) else begin
            errors++;
            $error("FAIL pending pos=%0d got=%b exp=%b", m_pos, bus.o_pending, m_pend_v);
        end
    endtask

    // One clock: drive inputs, check this cycle's outputs, then advance the model.
    task automatic cycle(input bit rst, input bit ld, input logic [15:0] bcd, input logic [3:0] dp);
        i_reset     = rst;
        bus.i_load  = ld;
        bus.i_bcd   = bcd;
        bus.i_dp    = dp;
        #1;
        if (m_valid) check_outputs();
        @(posedge i_clk);
        if (rst) begin
            m_valid    = 1;
            m_pos      = 0;
            m_disp_bcd = '0;
            m_disp_dp  = '0;
            m_pend_bcd = '0;
            m_pend_dp  = '0;
            m_pend_v   = 0;
        end else if (m_valid) begin
            if (m_pos == 0) begin
                if (ld) begin
                    m_disp_bcd = bcd;
                    m_disp_dp  = dp;
                    m_pend_v   = 0;
                end else if (m_pend_v) begin
                    m_disp_bcd = m_pend_bcd;
                    m_disp_dp  = m_pend_dp;
                    m_pend_v   = 0;
                end
            end else if (ld) begin
                m_pend_bcd = bcd;
                m_pend_dp  = dp;
                m_pend_v   = 1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        @(negedge i_clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0);
    endtask

    task automatic goto_pos(int p);
        for (int i = 0; i < FRAME && m_pos != p; i++) cycle(0, 0, '0, '0);
    endtask

    initial begin
        i_reset    = 1'b1;
        bus.i_load = 1'b0;
        bus.i_bcd  = '0;
        bus.i_dp   = '0;
        @(negedge i_clk);

        // Reset, then two full frames with no load: zeros on every digit.
        cycle(1, 0, '0, '0);
        cycle(1, 0, '0, '0);
        idle(2*FRAME);

        // Mid-frame load is held until the next frame start.
        goto_pos(5);
        cycle(0, 1, 16'h0407, 4'b0010);
        idle(2*FRAME);

        // Two loads in one frame: the later one is shown.
        goto_pos(3);
        cycle(0, 1, 16'h1111, 4'b0000);
        goto_pos(8);
        cycle(0, 1, 16'h2222, 4'b0000);
        idle(FRAME + 5);

        // Load exactly on the START cycle shows in that same frame.
        goto_pos(0);
        cycle(0, 1, 16'h00E9, 4'b0000);
        idle(FRAME);

        // Blank codes with decimal points lit.
        goto_pos(2);
        cycle(0, 1, 16'hFDCB, 4'b1111);
        idle(FRAME + 2);
        goto_pos(2);
        cycle(0, 1, 16'h0A0A, 4'b0101);
        idle(FRAME + 2);
        goto_pos(2);
        cycle(0, 1, 16'h0E00, 4'b0000);
        idle(FRAME + 2);

        // Reset during digit 2 with a load pending.
        goto_pos(3);
        cycle(0, 1, 16'h5678, 4'b1001);
        goto_pos(10);
        cycle(1, 0, '0, '0);
        idle(FRAME + 5);

        // Random loads and occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit          rst, ld;
            logic [15:0] b;
            logic [3:0]  p;
            rst = ($urandom_range(99) == 0);
            ld  = ($urandom_range(5) == 0);
            b   = 16'($urandom);
            if ($urandom_range(2) == 0) b[15:8] = 8'h00;
            p   = 4'($urandom);
            cycle(rst, ld, b, p);
        end
        idle(FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-cathode 7-segment display with decimal points.
- Replaces the fixed 3/4-digit scanner; digit count, on-time and inter-frame gap are configurable.
- Display values are double-buffered. A load strobe captures them, and they are applied only at a frame boundary, so no digit ever tears mid-scan.
- Sits between the BCD converter / any value source and the display pads.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- DIGIT_ON_CYCLES, 500, clock cycles each digit is enabled (>=1).
- GAP_CYCLES, 20000, blank cycles after the last digit of each frame (0 = no gap).
- CNT_W, 16, width of the internal cycle counter; must hold max(DIGIT_ON_CYCLES, GAP_CYCLES)-1.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_load  in  1  single-cycle strobe: capture i_bcd/i_dp
- i_bcd  in  NUM_DIGITS*4  digit codes, digit k at [4k+3:4k], digit 0 = least significant
- i_dp  in  NUM_DIGITS  decimal point per digit
- o_segments  out  8  bit0..bit6 = segments a..g, bit7 = dp; active-high
- o_digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high
- o_frame_done  out  1  one-cycle pulse at the end of each frame
- o_pending  out  1  high while a loaded value waits for the next frame start

Behaviour:
- Interface: reset i_reset, synchronous, active-high; clock i_clk.
- Registers:
  - pending: bcd, dp, valid.
  - active: bcd, dp.
  - state: START, SCAN, GAP.
  - digit index idx.
  - counter cnt.
- Outputs are decoded from registered state only; there is no combinational path from inputs.
- Reset:
  - state=START, idx=0, cnt=0.
  - active and pending cleared; pending valid=0.
  - Outputs during and after the reset cycle: o_segments=0, o_digit_sel=0, o_frame_done=0, o_pending=0.
- START (1 cycle):
  - Outputs blank.
  - If pending valid: active<=pending, valid<=0.
  - Next state SCAN, idx=0, cnt=0.
- SCAN:
  - o_digit_sel=1<<idx; o_segments=decode(active digit idx), with bit7=active dp[idx].
  - cnt increments each cycle. At cnt==DIGIT_ON_CYCLES-1: cnt<=0.
    - If idx<NUM_DIGITS-1: idx++.
    - Otherwise: go to GAP, or to START if GAP_CYCLES==0.
- GAP:
  - Outputs blank.
  - cnt increments; at cnt==GAP_CYCLES-1 go to START.
- Frame length: 1 + NUM_DIGITS*DIGIT_ON_CYCLES + GAP_CYCLES cycles.
- o_frame_done: high for exactly the first cycle after the last digit's window, i.e. the first GAP cycle, or the START cycle when GAP_CYCLES==0.
- Decode (gfedcba):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - 0xE = minus (0x40).
  - 0xA-0xD and 0xF = blank (0x00).
  - dp is independent of the code.
- Load rules:
  - i_load in any non-START cycle: pending<=inputs, valid<=1. Latest load wins; there is no overflow.
  - i_load in a START cycle: inputs go directly to active and pending valid<=0, so the new data shows in this frame.
- o_pending mirrors pending valid.
- Reset mid-frame: the scan aborts immediately, the display blanks, and any pending load is discarded.

Optional Feature:
- Macro: SEG7_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: a digit whose code is 0 is blanked (segments a..g = 0) if every higher-index digit is 0 or blank-coded.
  - Digit 0 is never blanked.
  - The dp bit is still driven.
- Undefined: all zeros are displayed.

Test Plan (NUM_DIGITS=4, DIGIT_ON_CYCLES=4, GAP_CYCLES=3, frame=20 cycles):
- Reset, then release with no load -> START blank. Each digit shows 0x3F for 4 cycles with sel 0001, 0010, 0100, 1000. o_frame_done pulses in the cycle after the 16th SCAN cycle. The frame repeats every 20 cycles.
- Load i_bcd=0x0407, i_dp=0010 mid-frame -> o_pending=1 and the current frame is unchanged. Next frame shows digit0=0x07, digit1=0x3F|0x80, digit2=0x66, digit3=0x3F (0x00 with the macro defined). o_pending drops in the START cycle.
- Two loads in one frame (0x1111, then 0x2222) -> next frame shows 0x5B on all digits.
- Load asserted exactly in a START cycle with 0x00E9 -> the same frame shows 0x6F, 0x40, 0x3F, 0x3F (with the macro: 0x6F, 0x40, 0x00, 0x00). o_pending stays 0.
- Codes 0xA-0xD, 0xF with dp=1 -> o_segments=0x80 for those digits.
- i_reset asserted during digit 2 -> the next cycle has o_digit_sel=0, o_segments=0, o_pending=0. After release, the scan restarts at START/digit 0 with value 0.
